cache_port_arbiter: RTL and testbench

Shares the single-port cache system between the RISC-V instruction-fetch port (read-only) and the data port (read/write). Accepts one request at a time, holds the cache command stable across miss stalls, and returns read data with a one-cycle done pulse to the winning requester. Sits between the core's fetch/LSU stages and the cache system, and also keeps a saturating count of stall cycles for performance debug.

---
 rtl/cache_arb_pkg.sv | 24 ++
 rtl/cache_port_arbiter_if.sv | 43 ++++
 rtl/cache_arb_pick.sv | 30 +++
 rtl/cache_port_arbiter.sv | 129 ++++++++++++
 tb/tb_cache_port_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_arb_pkg.sv
// Shared types and constants for the I/D cache port arbiter.
// Port ids, FSM state enum and the latched request bundle.
package cache_arb_pkg;

    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 32;
    localparam int CNT_W_DEF = 16;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arbState_e;

    typedef struct packed {
        logic              port;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/cache_port_arbiter_if.sv
// Requester and cache-side bus of the cache port arbiter.
// master = arbiter view, slave = requesters plus cache view.
interface cache_port_arbiter_if;
    import cache_arb_pkg::*;

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_done;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_done;
    logic [DATA_W-1:0] d_rdata;

    logic              c_mem_read;
    logic              c_mem_write;
    logic [ADDR_W-1:0] c_address;
    logic [DATA_W-1:0] c_datain;
    logic              c_stall;
    logic [DATA_W-1:0] c_dataout;

    modport master (
        input  i_req, i_addr,
        input  d_req, d_we, d_addr, d_wdata,
        input  c_stall, c_dataout,
        output i_done, i_rdata,
        output d_done, d_rdata,
        output c_mem_read, c_mem_write, c_address, c_datain
    );

    modport slave (
        output i_req, i_addr,
        output d_req, d_we, d_addr, d_wdata,
        output c_stall, c_dataout,
        input  i_done, i_rdata,
        input  d_done, d_rdata,
        input  c_mem_read, c_mem_write, c_address, c_datain
    );

endinterface

// File: rtl/cache_arb_pick.sv
// Combinational winner select between fetch and data requests.
// CACHE_ARB_FIXED_PRIO_EN: data wins ties, no last-grant input.
module cache_arb_pick
    import cache_arb_pkg::*;
(
    input  logic iReq,
    input  logic dReq,
`ifndef CACHE_ARB_FIXED_PRIO_EN
    input  logic lastQ,
`endif
    output logic grantId,
    output logic grantValid
);

    // pick a winner; ties go to data or to the port not granted last
    always_comb begin
        grantValid = iReq | dReq;
        grantId    = PORT_I;
        if (iReq && dReq) begin
`ifdef CACHE_ARB_FIXED_PRIO_EN
            grantId = PORT_D;
`else
            grantId = (lastQ == PORT_I) ? PORT_D : PORT_I;
`endif
        end else if (dReq) begin
            grantId = PORT_D;
        end
    end

endmodule

// File: rtl/cache_port_arbiter.sv
// Shares one cache between fetch and data ports, one access at a time.
// CACHE_ARB_FIXED_PRIO_EN selects fixed data priority over round-robin.
module cache_port_arbiter
    import cache_arb_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    cache_port_arbiter_if.master bus,
    output logic                 busy,
    output logic [CNT_W-1:0]     stall_cnt
);

    arbState_e         state;
    arbState_e         stateNext;
    req_t              reqQ;
    logic              grantId;
    logic              grantValid;
    logic              load;
    logic              finish;
    logic              iDoneQ;
    logic              dDoneQ;
    logic [DATA_W-1:0] iRdataQ;
    logic [DATA_W-1:0] dRdataQ;
    logic [CNT_W-1:0]  stallCntQ;
`ifndef CACHE_ARB_FIXED_PRIO_EN
    logic              lastQ;
`endif

    cache_arb_pick uPick (
        .iReq       (bus.i_req),
        .dReq       (bus.d_req),
`ifndef CACHE_ARB_FIXED_PRIO_EN
        .lastQ      (lastQ),
`endif
        .grantId    (grantId),
        .grantValid (grantValid)
    );

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= stateNext;
    end

    // next state and cache command, driven only from latched request
    always_comb begin
        stateNext       = state;
        load            = 1'b0;
        finish          = 1'b0;
        bus.c_mem_read  = 1'b0;
        bus.c_mem_write = 1'b0;
        bus.c_address   = '0;
        bus.c_datain    = '0;
        unique case (state)
            IDLE: begin
                if (grantValid) begin
                    load      = 1'b1;
                    stateNext = BUSY;
                end
            end
            BUSY: begin
                bus.c_mem_read  = !reqQ.we;
                bus.c_mem_write = reqQ.we;
                bus.c_address   = reqQ.addr;
                bus.c_datain    = reqQ.wdata;
                if (!bus.c_stall) begin
                    finish    = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: ;
        endcase
    end

    // latch the winner's request and remember who was granted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reqQ  <= '0;
`ifndef CACHE_ARB_FIXED_PRIO_EN
            lastQ <= PORT_D;
`endif
        end else if (load) begin
            if (grantId == PORT_D) begin
                reqQ <= '{port: PORT_D, we: bus.d_we,
                          addr: bus.d_addr, wdata: bus.d_wdata};
            end else begin
                reqQ <= '{port: PORT_I, we: 1'b0,
                          addr: bus.i_addr, wdata: '0};
            end
`ifndef CACHE_ARB_FIXED_PRIO_EN
            lastQ <= grantId;
`endif
        end
    end

    // one-cycle done pulse and registered read data to the winner
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iDoneQ  <= 1'b0;
            dDoneQ  <= 1'b0;
            iRdataQ <= '0;
            dRdataQ <= '0;
        end else begin
            iDoneQ <= finish && (reqQ.port == PORT_I);
            dDoneQ <= finish && (reqQ.port == PORT_D);
            if (finish && (reqQ.port == PORT_I)) iRdataQ <= bus.c_dataout;
            if (finish && (reqQ.port == PORT_D)) dRdataQ <= bus.c_dataout;
        end
    end

    // saturating count of stalled busy cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stallCntQ <= '0;
        end else if (state == BUSY && bus.c_stall && !(&stallCntQ)) begin
            stallCntQ <= stallCntQ + CNT_W'(1);
        end
    end

    assign bus.i_done  = iDoneQ;
    assign bus.i_rdata = iRdataQ;
    assign bus.d_done  = dDoneQ;
    assign bus.d_rdata = dRdataQ;
    assign busy        = (state == BUSY);
    assign stall_cnt   = stallCntQ;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Scoreboard bench for cache_port_arbiter: directed cases then random traffic.
// Honours CACHE_ARB_FIXED_PRIO_EN for the arbitration expectation.
module tb_cache_port_arbiter;
    import cache_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        busy;
    logic [15:0] stallCnt;

    cache_port_arbiter_if bus ();

    cache_port_arbiter #(.CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy),
        .stall_cnt (stallCnt)
    );

    typedef struct {
        bit          we;
        logic [31:0] rd;
    } doneExp_t;

    typedef struct {
        bit          we;
        logic [9:0]  addr;
        logic [31:0] wdata;
    } grantExp_t;

    doneExp_t  iQ[$];
    doneExp_t  dQ[$];
    grantExp_t gQ[$];

    int          vecs = 0;
    int          errs = 0;
    int          cyc = 0;
    bit          lastG = 1'b1;
    logic [15:0] expStall = '0;
    bit          randMode = 1'b0;
    int          stallLeft = 0;

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [31:0] hashD(logic [9:0] a);
        return {6'h2B, a, 6'h15, ~a};
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] want);
        vecs++;
        if (act !== want) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endtask

    task automatic issue(bit p, bit we, logic [9:0] a, logic [31:0] wd);
        doneExp_t e;
        e.we = (p == PORT_D) ? we : 1'b0;
        e.rd = hashD(a);
        if (p == PORT_D) begin
            bus.d_req = 1'b1; bus.d_we = we;
            bus.d_addr = a; bus.d_wdata = wd;
            dQ.push_back(e);
        end else begin
            bus.i_req = 1'b1; bus.i_addr = a;
            iQ.push_back(e);
        end
    endtask

    task automatic drop(bit p);
        if (p == PORT_D) bus.d_req = 1'b0;
        else bus.i_req = 1'b0;
    endtask

    task automatic waitDone(bit p, int limit, output int lat);
        lat = -1;
        for (int n = 1; n <= limit; n++) begin
            @(negedge clk);
            if ((p == PORT_D) ? bus.d_done : bus.i_done) begin
                lat = n;
                break;
            end
        end
        if (lat < 0) check(p ? "d_done timeout" : "i_done timeout", 0, 1);
    endtask

    task automatic assertReset();
        rst = 1'b0;
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        iQ.delete(); dQ.delete(); gQ.delete();
        expStall = '0;
        lastG = PORT_D;
        stallLeft = 0;
    endtask

    task automatic doReset();
        assertReset();
        repeat (2) @(posedge clk);
        #1;
        check("rst i_done", bus.i_done, 0);
        check("rst d_done", bus.d_done, 0);
        check("rst i_rdata", bus.i_rdata, 0);
        check("rst d_rdata", bus.d_rdata, 0);
        check("rst c_mem_read", bus.c_mem_read, 0);
        check("rst c_mem_write", bus.c_mem_write, 0);
        check("rst c_address", 32'(bus.c_address), 0);
        check("rst c_datain", bus.c_datain, 0);
        check("rst busy", busy, 0);
        check("rst stall_cnt", 32'(stallCnt), 0);
        rst = 1'b1;
    endtask

    // cache stub: stall pattern plus address-derived read data
    initial begin
        bus.c_stall = 1'b0;
        bus.c_dataout = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.c_mem_read || bus.c_mem_write) begin
                if (randMode) begin
                    bus.c_stall = ($urandom_range(0, 2) == 0);
                end else if (stallLeft > 0) begin
                    bus.c_stall = 1'b1;
                    stallLeft--;
                end else begin
                    bus.c_stall = 1'b0;
                end
                bus.c_dataout = hashD(bus.c_address);
            end else begin
                bus.c_stall = randMode ? 1'($urandom_range(0, 1)) : 1'b0;
                bus.c_dataout = $urandom;
            end
        end
    end

    // monitor: done responses, cache command, stall count, arbitration
    initial begin
        doneExp_t  e;
        grantExp_t g;
        bit        w;
        bit        act;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                if (bus.i_done) begin
                    if (iQ.size() == 0) check("spurious i_done", 1, 0);
                    else begin
                        e = iQ.pop_front();
                        check("i_rdata", bus.i_rdata, e.rd);
                    end
                end
                if (bus.d_done) begin
                    if (dQ.size() == 0) check("spurious d_done", 1, 0);
                    else begin
                        e = dQ.pop_front();
                        if (!e.we) check("d_rdata", bus.d_rdata, e.rd);
                    end
                end
                check("stall_cnt", 32'(stallCnt), 32'(expStall));
                act = bus.c_mem_read | bus.c_mem_write;
                check("busy", busy, act);
                if (act) begin
                    if (gQ.size() == 0) check("unexpected access", 1, 0);
                    else begin
                        g = gQ[0];
                        check("c_mem_write", bus.c_mem_write, g.we);
                        check("c_mem_read", bus.c_mem_read, !g.we);
                        check("c_address", 32'(bus.c_address), 32'(g.addr));
                        if (g.we) check("c_datain", bus.c_datain, g.wdata);
                        if (bus.c_stall) begin
                            if (expStall != 16'hFFFF) expStall++;
                        end else begin
                            void'(gQ.pop_front());
                        end
                    end
                end else begin
                    check("missing access", 32'(gQ.size()), 0);
                    if (bus.i_req || bus.d_req) begin
`ifdef CACHE_ARB_FIXED_PRIO_EN
                        w = bus.d_req;
`else
                        if (bus.i_req && bus.d_req) w = !lastG;
                        else w = bus.d_req;
`endif
                        lastG = w;
                        if (w) begin
                            g.we = bus.d_we;
                            g.addr = bus.d_addr;
                            g.wdata = bus.d_wdata;
                        end else begin
                            g.we = 1'b0;
                            g.addr = bus.i_addr;
                            g.wdata = '0;
                        end
                        gQ.push_back(g);
                    end
                end
            end
        end
    end

    task automatic tieTest();
        bit want[4];
        int t[4];
        bit p;
        bit seen;
        int lat;
`ifdef CACHE_ARB_FIXED_PRIO_EN
        want = '{1'b1, 1'b1, 1'b1, 1'b1};
`else
        want = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
        issue(PORT_I, 1'b0, 10'h010, '0);
        issue(PORT_D, 1'b0, 10'h020, '0);
        for (int k = 0; k < 4; k++) begin
            seen = 1'b0;
            for (int n = 0; n < 20 && !seen; n++) begin
                @(negedge clk);
                seen = bus.i_done | bus.d_done;
            end
            if (!seen) begin
                check("tie done timeout", 0, 1);
                break;
            end
            p = bus.d_done;
            t[k] = cyc;
            check("tie grant order", 32'(p), 32'(want[k]));
            if (k > 0) check("tie done spacing", 32'(t[k] - t[k-1]), 2);
            if (k < 3) issue(p, 1'b0, 10'h040 + 10'(k * 4), '0);
            else drop(p);
        end
        if (bus.i_req) begin waitDone(PORT_I, 20, lat); drop(PORT_I); end
        if (bus.d_req) begin waitDone(PORT_D, 20, lat); drop(PORT_D); end
        @(posedge clk); #1;
    endtask

    task automatic randPort(bit p, int count);
        int lat;
        for (int j = 0; j < count; j++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(p, (p == PORT_D) ? 1'($urandom_range(0, 1)) : 1'b0,
                  10'($urandom_range(0, 1023)), $urandom);
            waitDone(p, 400, lat);
            drop(p);
        end
    endtask

    initial begin
        int lat;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        bus.d_addr = '0; bus.d_wdata = '0;

        doReset();

        issue(PORT_I, 1'b0, 10'h008, '0);
        waitDone(PORT_I, 20, lat);
        drop(PORT_I);
        check("fetch hit latency", 32'(lat), 3);
        @(posedge clk); #1;
        check("fetch hit stall_cnt", 32'(stallCnt), 0);

        stallLeft = 4;
        issue(PORT_D, 1'b1, 10'h005, 32'h5);
        waitDone(PORT_D, 30, lat);
        drop(PORT_D);
        check("write miss latency", 32'(lat), 7);
        @(posedge clk); #1;
        check("write miss stall_cnt", 32'(stallCnt), 4);

        stallLeft = 3;
        issue(PORT_D, 1'b0, 10'h004, '0);
        fork
            begin
                repeat (2) @(posedge clk);
                #1 bus.d_addr = 10'h00C;
            end
        join_none
        waitDone(PORT_D, 30, lat);
        drop(PORT_D);
        check("addr change latency", 32'(lat), 6);
        @(posedge clk); #1;

        stallLeft = 1000;
        issue(PORT_D, 1'b0, 10'h030, '0);
        repeat (3) @(posedge clk);
        #1;
        check("pre-reset c_mem_read", bus.c_mem_read, 1);
        assertReset();
        #1;
        check("reset drops c_mem_read", bus.c_mem_read, 0);
        check("reset drops busy", busy, 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset stall_cnt", 32'(stallCnt), 0);
        check("reset no d_done", bus.d_done, 0);
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        tieTest();

        stallLeft = 70000;
        issue(PORT_D, 1'b0, 10'h3FF, '0);
        waitDone(PORT_D, 70100, lat);
        drop(PORT_D);
        check("saturation latency", 32'(lat), 70003);
        @(posedge clk); #1;
        check("stall_cnt saturated", 32'(stallCnt), 32'hFFFF);

        randMode = 1'b1;
        fork
            randPort(PORT_I, 120);
            randPort(PORT_D, 120);
        join
        randMode = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("iQ drained", 32'(iQ.size()), 0);
        check("dQ drained", 32'(dQ.size()), 0);
        check("gQ drained", 32'(gQ.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
